// File: rtl/vram_slot_arbiter.sv
// vram_slot_arbiter: two-cycle slot SRAM arbiter for video > cpu > dma with fixed read latency.
// Optional CPU anti-starvation guard enabled by defining CPU_STARVE_GUARD_EN.
module vram_slot_arbiter #(
  parameter int ADDR_W = 19,
  parameter logic [18:0] PAL_BASE = 19'h7FFC0,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk28,
  input  logic              rst,
  input  logic              video_req,
  input  logic [14:0]       video_addr,
  input  logic              video_is_up,
  input  logic              video_page,
  output logic              video_ack,
  output logic              video_valid,
  output logic [7:0]        video_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_valid,
  output logic [7:0]        cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [7:0]        dma_wdata,
  output logic              dma_ack,
  output logic              dma_valid,
  output logic [7:0]        dma_rdata,
  output logic [ADDR_W-1:0] ram_a,
  output logic [7:0]        ram_dq_out,
  output logic              ram_dq_oe,
  input  logic [7:0]        ram_dq_in,
  output logic              ram_oe_n,
  output logic              ram_we_n
);
  typedef enum logic [1:0] {NONE, VID, CPU, DMA} owner_t;
  owner_t owner, win;
  logic own_we, phase, win_we, cpu_force, unused;
  logic [18:0] vaddr;
  logic [ADDR_W-1:0] win_addr;
  logic [7:0] win_wdata;
  assign unused = video_addr[14];
  assign vaddr = video_is_up ? {PAL_BASE[18:6], video_addr[5:0]}
                             : {2'b00, video_page ? 3'd7 : 3'd5, video_addr[13:0]};
`ifdef CPU_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic [CW-1:0] starve;
  assign cpu_force = cpu_req && starve == CW'(STARVE_MAX);
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) starve <= '0;
    else if (phase) starve <= (!cpu_req || win == CPU) ? '0 : (win == VID ? starve + 1'b1 : starve);
  end
`else
  assign cpu_force = 1'b0;
`endif
  always_comb begin
    win = cpu_force ? CPU : video_req ? VID : cpu_req ? CPU : dma_req ? DMA : NONE;
    win_we = win == CPU ? cpu_we : win == DMA ? dma_we : 1'b0;
    win_addr = win == VID ? ADDR_W'(vaddr) : win == CPU ? cpu_addr : win == DMA ? dma_addr : '0;
    win_wdata = win == CPU ? cpu_wdata : win == DMA ? dma_wdata : 8'h00;
  end
  // phase 1 -> 0 edge opens a slot; the previous slot's read data is captured on the same edge
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      phase <= 1'b0;
      owner <= NONE;
      own_we <= 1'b0;
      {video_ack, cpu_ack, dma_ack} <= 3'b000;
      {video_valid, cpu_valid, dma_valid} <= 3'b000;
      video_data <= 8'h00;
      cpu_rdata <= 8'h00;
      dma_rdata <= 8'h00;
      ram_a <= '0;
      ram_dq_out <= 8'h00;
      ram_dq_oe <= 1'b0;
      ram_oe_n <= 1'b1;
      ram_we_n <= 1'b1;
    end else begin
      phase <= ~phase;
      if (phase) begin
        video_ack <= win == VID;
        cpu_ack <= win == CPU;
        dma_ack <= win == DMA;
        owner <= win;
        own_we <= win_we;
        ram_a <= win_addr;
        ram_dq_out <= win_wdata;
        ram_oe_n <= win == NONE || win_we;
        ram_dq_oe <= win_we;
        ram_we_n <= 1'b1;
        video_valid <= owner == VID;
        cpu_valid <= owner == CPU && !own_we;
        dma_valid <= owner == DMA && !own_we;
        if (owner == VID) video_data <= ram_dq_in;
        if (owner == CPU && !own_we) cpu_rdata <= ram_dq_in;
        if (owner == DMA && !own_we) dma_rdata <= ram_dq_in;
      end else begin
        {video_ack, cpu_ack, dma_ack} <= 3'b000;
        {video_valid, cpu_valid, dma_valid} <= 3'b000;
        ram_we_n <= !(owner != NONE && own_we);
      end
    end
  end
endmodule

// File: tb/tb_vram_slot_arbiter.sv
// tb_vram_slot_arbiter: directed scenarios plus randomized traffic against a slot-level reference model.
module tb_vram_slot_arbiter;
  logic clk28 = 1'b0, rst = 1'b1;
  logic video_req, video_is_up, video_page;
  logic [14:0] video_addr;
  logic video_ack, video_valid;
  logic [7:0] video_data;
  logic cpu_req, cpu_we, cpu_ack, cpu_valid;
  logic [18:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic dma_req, dma_we, dma_ack, dma_valid;
  logic [18:0] dma_addr;
  logic [7:0] dma_wdata, dma_rdata;
  logic [18:0] ram_a;
  logic [7:0] ram_dq_out, ram_dq_in;
  logic ram_dq_oe, ram_oe_n, ram_we_n;
  int checks = 0, errors = 0;

  always #5 clk28 = ~clk28;

  vram_slot_arbiter dut (
    .clk28(clk28), .rst(rst),
    .video_req(video_req), .video_addr(video_addr), .video_is_up(video_is_up), .video_page(video_page),
    .video_ack(video_ack), .video_valid(video_valid), .video_data(video_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_valid(dma_valid), .dma_rdata(dma_rdata),
    .ram_a(ram_a), .ram_dq_out(ram_dq_out), .ram_dq_oe(ram_dq_oe), .ram_dq_in(ram_dq_in),
    .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  function automatic logic [18:0] vmap(input logic [14:0] a, input logic up, input logic pg);
    return up ? 19'h7FFC0 + 19'(a % 64) : 19'((pg ? 7 : 5) * 16384 + int'(a % 16384));
  endfunction

  task automatic clear_inputs;
    {video_req, video_is_up, video_page, cpu_req, cpu_we, dma_req, dma_we} = '0;
    video_addr = '0; cpu_addr = '0; dma_addr = '0;
    cpu_wdata = '0; dma_wdata = '0; ram_dq_in = '0;
  endtask

  // returns at the first sample point after release (cycle 0, phase 0)
  task automatic do_reset;
    @(negedge clk28);
    rst = 1'b1;
    clear_inputs();
    @(negedge clk28);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk28);
    rst = 1'b1;
    clear_inputs();
    #1;
    checks++;
    if ({video_ack, cpu_ack, dma_ack, video_valid, cpu_valid, dma_valid} !== 6'b0) begin
      errors++; $display("FAIL reset_handshake got %b exp 000000", {video_ack, cpu_ack, dma_ack, video_valid, cpu_valid, dma_valid});
    end
    checks++;
    if ({video_data, cpu_rdata, dma_rdata} !== 24'h0) begin
      errors++; $display("FAIL reset_rdata got %h exp 000000", {video_data, cpu_rdata, dma_rdata});
    end
    checks++;
    if (ram_a !== 19'h0 || ram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL reset_ram_a_oe got %h/%b exp 00000/0", ram_a, ram_dq_oe);
    end
    checks++;
    if (ram_oe_n !== 1'b1 || ram_we_n !== 1'b1) begin
      errors++; $display("FAIL reset_strobes got %b%b exp 11", ram_oe_n, ram_we_n);
    end
    @(negedge clk28);
    rst = 1'b0;
  endtask

  task automatic test_video_map;
    logic [14:0] ta [2] = '{15'h003F, 15'h0000};
    logic [18:0] te [2] = '{19'h7FFFF, 19'h1C000};
    do_reset();
    video_req = 1'b1; video_addr = 15'h4123; ram_dq_in = 8'hA5;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk28);
      checks++;
      if (video_ack !== (k == 2 || k == 4 || k == 6)) begin
        errors++; $display("FAIL video_ack k=%0d got %b", k, video_ack);
      end
      checks++;
      if (video_valid !== (k == 4 || k == 6)) begin
        errors++; $display("FAIL video_valid k=%0d got %b", k, video_valid);
      end
      if (k == 2) begin
        checks++;
        if (ram_a !== 19'h14123 || ram_oe_n !== 1'b0) begin
          errors++; $display("FAIL video_ram_a got %h/%b exp 14123/0", ram_a, ram_oe_n);
        end
      end
      if (k == 4) begin
        checks++;
        if (video_data !== 8'hA5) begin
          errors++; $display("FAIL video_data got %h exp a5", video_data);
        end
      end
    end
    for (int i = 0; i < 2; i++) begin
      do_reset();
      video_req = 1'b1; video_addr = ta[i]; video_is_up = (i == 0); video_page = (i == 1);
      repeat (2) @(negedge clk28);
      checks++;
      if (ram_a !== te[i] || video_ack !== 1'b1) begin
        errors++; $display("FAIL video_map_%0d got %h/%b exp %h/1", i, ram_a, video_ack, te[i]);
      end
    end
  endtask

  task automatic test_cpu_write;
    int acks = 0, we_low = 0, oe_hi = 0, vals = 0;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 8'h3C;
    for (int k = 0; k <= 8; k++) begin
      if (k > 0) @(negedge clk28);
      acks += int'(cpu_ack); we_low += int'(!ram_we_n); oe_hi += int'(ram_dq_oe); vals += int'(cpu_valid);
      if (k == 3) begin
        checks++;
        if (ram_we_n !== 1'b0 || ram_a !== 19'h00010 || ram_dq_out !== 8'h3C || ram_oe_n !== 1'b1) begin
          errors++; $display("FAIL cpu_write_bus got we_n=%b a=%h d=%h oe_n=%b", ram_we_n, ram_a, ram_dq_out, ram_oe_n);
        end
      end
      if (cpu_ack) cpu_req = 1'b0;
    end
    checks++;
    if (acks != 1 || we_low != 1 || oe_hi != 2 || vals != 0) begin
      errors++; $display("FAIL cpu_write_counts got ack=%0d we=%0d oe=%0d val=%0d exp 1 1 2 0", acks, we_low, oe_hi, vals);
    end
  endtask

  task automatic test_priority;
    logic [2:0] exp [10] = '{3'b000, 3'b000, 3'b100, 3'b000, 3'b100, 3'b000, 3'b010, 3'b000, 3'b001, 3'b000};
    do_reset();
    video_req = 1'b1; cpu_req = 1'b1; dma_req = 1'b1; cpu_addr = 19'h100; dma_addr = 19'h200;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk28);
      checks++;
      if ({video_ack, cpu_ack, dma_ack} !== exp[k]) begin
        errors++; $display("FAIL priority k=%0d got %b exp %b", k, {video_ack, cpu_ack, dma_ack}, exp[k]);
      end
      if (k == 4) video_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
      if (dma_ack) dma_req = 1'b0;
    end
  endtask

`ifdef CPU_STARVE_GUARD_EN
  task automatic test_starve;
    logic [1:0] exp [11] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};
    do_reset();
    video_req = 1'b1; cpu_req = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk28);
      checks++;
      if ({video_ack, cpu_ack} !== exp[k]) begin
        errors++; $display("FAIL starve k=%0d got %b exp %b", k, {video_ack, cpu_ack}, exp[k]);
      end
      if (cpu_ack) cpu_req = 1'b0;
    end
  endtask
`endif

  task automatic test_mid_reset;
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h00010; cpu_wdata = 8'h3C;
    repeat (2) @(negedge clk28);
    cpu_req = 1'b0;
    @(negedge clk28);
    checks++;
    if (ram_we_n !== 1'b0) begin
      errors++; $display("FAIL midrst_pre_we got %b exp 0", ram_we_n);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (ram_we_n !== 1'b1 || ram_dq_oe !== 1'b0) begin
      errors++; $display("FAIL midrst_async got we_n=%b oe=%b exp 1 0", ram_we_n, ram_dq_oe);
    end
    @(negedge clk28);
    rst = 1'b0;
    for (int k = 0; k <= 6; k++) begin
      if (k > 0) @(negedge clk28);
      checks++;
      if ({video_ack, cpu_ack, dma_ack} !== ((k == 4 || k == 6) ? 3'b100 : 3'b000)) begin
        errors++; $display("FAIL midrst_ack k=%0d got %b", k, {video_ack, cpu_ack, dma_ack});
      end
      checks++;
      if ({video_valid, cpu_valid, dma_valid, ram_we_n} !== ((k == 6) ? 4'b1001 : 4'b0001)) begin
        errors++; $display("FAIL midrst_valid k=%0d got %b", k, {video_valid, cpu_valid, dma_valid, ram_we_n});
      end
      if (k == 3) video_req = 1'b1;
    end
  endtask

  // slot-level model: each slot is decided from the requests visible just before it opens
  task automatic test_random;
    int s_own = 0, w = 0, cnt = 0;
    logic s_we = 1'b0, force_c;
    logic [18:0] s_addr = '0;
    logic [7:0] s_wd = '0, e_vd = '0, e_cd = '0, e_dd = '0;
    logic [2:0] e_ack, e_val;
    do_reset();
    for (int k = 0; k < 1200; k++) begin
      if (k > 0) @(negedge clk28);
      e_ack = 3'b000; e_val = 3'b000;
      if (k % 2 == 0 && k >= 2) begin
        if (!s_we && s_own == 1) begin e_val = 3'b100; e_vd = ram_dq_in; end
        if (!s_we && s_own == 2) begin e_val = 3'b010; e_cd = ram_dq_in; end
        if (!s_we && s_own == 3) begin e_val = 3'b001; e_dd = ram_dq_in; end
`ifdef CPU_STARVE_GUARD_EN
        force_c = cpu_req && cnt == 3;
`else
        force_c = 1'b0;
`endif
        w = force_c ? 2 : video_req ? 1 : cpu_req ? 2 : dma_req ? 3 : 0;
        cnt = (!cpu_req || w == 2) ? 0 : (w == 1 ? cnt + 1 : cnt);
        s_own = w;
        s_we = (w == 2) ? cpu_we : (w == 3) ? dma_we : 1'b0;
        s_addr = (w == 1) ? vmap(video_addr, video_is_up, video_page) : (w == 2) ? cpu_addr : (w == 3) ? dma_addr : '0;
        s_wd = (w == 2) ? cpu_wdata : dma_wdata;
        e_ack = (w == 1) ? 3'b100 : (w == 2) ? 3'b010 : (w == 3) ? 3'b001 : 3'b000;
      end
      checks++;
      if ({video_ack, cpu_ack, dma_ack} !== e_ack) begin
        errors++; $display("FAIL rnd_ack k=%0d got %b exp %b", k, {video_ack, cpu_ack, dma_ack}, e_ack);
      end
      checks++;
      if ({video_valid, cpu_valid, dma_valid} !== e_val) begin
        errors++; $display("FAIL rnd_valid k=%0d got %b exp %b", k, {video_valid, cpu_valid, dma_valid}, e_val);
      end
      checks++;
      if ({video_data, cpu_rdata, dma_rdata} !== {e_vd, e_cd, e_dd}) begin
        errors++; $display("FAIL rnd_rdata k=%0d got %h exp %h", k, {video_data, cpu_rdata, dma_rdata}, {e_vd, e_cd, e_dd});
      end
      checks++;
      if ({ram_oe_n, ram_dq_oe, ram_we_n} !== {!(s_own != 0 && !s_we), s_own != 0 && s_we, !(k % 2 == 1 && s_own != 0 && s_we)}) begin
        errors++; $display("FAIL rnd_strobes k=%0d got %b own=%0d we=%b", k, {ram_oe_n, ram_dq_oe, ram_we_n}, s_own, s_we);
      end
      if (s_own != 0) begin
        checks++;
        if (ram_a !== s_addr || (s_we && ram_dq_out !== s_wd)) begin
          errors++; $display("FAIL rnd_bus k=%0d got %h/%h exp %h/%h", k, ram_a, ram_dq_out, s_addr, s_wd);
        end
      end
      video_req = ($urandom % 10) < 4;
      video_addr = 15'($urandom); video_is_up = 1'($urandom); video_page = 1'($urandom);
      cpu_req = 1'($urandom); cpu_we = 1'($urandom); cpu_addr = 19'($urandom); cpu_wdata = 8'($urandom);
      dma_req = 1'($urandom); dma_we = 1'($urandom); dma_addr = 19'($urandom); dma_wdata = 8'($urandom);
      ram_dq_in = 8'($urandom);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_video_map();
    test_cpu_write();
    test_priority();
`ifdef CPU_STARVE_GUARD_EN
    test_starve();
`endif
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vram_slot_arbiter.md
Name: vram_slot_arbiter

Overview:
- Shares the single 512K external SRAM between three requesters: the video fetch engine, the CPU and the loader/DMA port.
- Runs fixed two-cycle memory slots on clk28.
- The video fetch engine has top priority; it issues bitmap, attribute and ULAplus palette reads.
- Maps video 15-bit screen addresses into the physical 19-bit space and returns read data with fixed latency.

Parameters:
- ADDR_W, 19, physical SRAM address width.
- PAL_BASE, 19'h7FFC0, physical base of the 64-byte palette area used for video_is_up reads.
- STARVE_MAX, 3, consecutive slots the CPU may lose to video before forced grant (optional feature only).

Ports:
- clk28  in  1  system clock, 28 MHz
- rst  in  1  asynchronous reset, active-high
- video_req  in  1  video read request, level, held until ack
- video_addr  in  15  video address; [13:0] offset within screen page, [14] ignored
- video_is_up  in  1  palette read; use PAL_BASE + video_addr[5:0]
- video_page  in  1  0 = 16K page 5, 1 = page 7
- video_ack  out  1  one-cycle grant pulse
- video_valid  out  1  one-cycle read-data-valid pulse
- video_data  out  8  read data, stable while video_valid is high
- cpu_req  in  1  CPU request, level, held until ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  physical address
- cpu_wdata  in  8  write data
- cpu_ack  out  1  grant pulse
- cpu_valid  out  1  read-data-valid pulse (reads only)
- cpu_rdata  out  8  read data
- dma_req, dma_we, dma_addr[ADDR_W], dma_wdata[8]  in  DMA request bundle, same rules as CPU
- dma_ack  out  1  grant pulse
- dma_valid  out  1  read-data-valid pulse
- dma_rdata  out  8  read data
- ram_a  out  ADDR_W  SRAM address
- ram_dq_out  out  8  SRAM write data
- ram_dq_oe  out  1  drive data bus
- ram_dq_in  in  8  SRAM read data
- ram_oe_n  out  1  SRAM output enable, active-low
- ram_we_n  out  1  SRAM write enable, active-low

Behaviour:
- Reset (async, immediate):
  - phase = 0; all acks, valids and rdata = 0.
  - ram_a = 0, ram_dq_oe = 0, ram_oe_n = 1, ram_we_n = 1.
  - Owner = NONE, starve counter = 0.
- Slot timing:
  - Free-running phase bit toggles every clk28 cycle; a slot = phase 0 (GRANT) + phase 1 (ACCESS).
  - Empty slots still consume two cycles.
- GRANT (phase 0):
  - Priority video > cpu > dma among asserted reqs.
  - Winner's ack is high for exactly this cycle.
  - ram_a, we and wdata are registered at this clock edge and are valid in ACCESS.
  - No winner: owner = NONE, ram_oe_n = 1.
- Video address mapping:
  - is_up = 1: ram_a = PAL_BASE[18:6] concatenated with video_addr[5:0].
  - is_up = 0: ram_a = {5'd5 or 5'd7 per video_page, video_addr[13:0]}.
  - Video never writes.
- ACCESS (phase 1):
  - Read: ram_oe_n = 0 for the whole slot; ram_dq_in is sampled at the end of phase 1.
  - Write: ram_dq_oe = 1 for the whole slot; ram_we_n = 0 in phase 1 only; ram_oe_n = 1.
- Read latency:
  - Owner's valid is high in the cycle after ACCESS (ack at t, valid at t+2), with rdata held until the next valid for that owner.
  - Writes produce no valid.
- Back-to-back grants to the same requester are allowed every slot (ack every 2 cycles).
- A requester that drops req before ack is not served; no ack is issued.
- Mid-slot reset aborts the access; ram_we_n returns to 1 asynchronously, and no valid is produced after reset release.
- req asserted in phase 1 is considered at the next phase 0; there is no combinational req-to-ack path.

Optional Feature:
- Macro: CPU_STARVE_GUARD_EN.
- When defined:
  - Counter increments on each GRANT where cpu_req = 1 and video wins.
  - Counter clears when the CPU is granted or cpu_req = 0.
  - When the counter equals STARVE_MAX, the CPU wins the next GRANT over video, and the video request stays pending.
- When undefined: strict priority; counter logic absent; the CPU may starve indefinitely.

Test Plan:
- Video only, page 0, addr 15'h4123, req held: ack at t, t+2, t+4; ram_a = 19'h14123; video_valid at t+2 with ram_dq_in = 8'hA5 returned on video_data.
- video_is_up = 1, addr 15'h003F: ram_a = 19'h7FFFF; page 1 non-up, addr 15'h0000: ram_a = 19'h1C000.
- CPU write 19'h00010 with data 8'h3C and no other reqs: cpu_ack once; ram_we_n low exactly one cycle (phase 1); ram_dq_oe high 2 cycles; no cpu_valid.
- video, cpu and dma all asserted on the same edge: grant order video, video... while video_req is held; after video drops: cpu then dma, one slot apart.
- CPU_STARVE_GUARD_EN with STARVE_MAX = 3, video and cpu held: video wins 3 slots, CPU wins the 4th, video resumes the 5th.
- Assert rst during phase 1 of a CPU write: ram_we_n = 1 the same cycle; after release no ack or valid until a fresh req; first GRANT occurs at phase 0.
